// File: rtl/br_table_ctrl_pkg.sv
// Shared constants and state encoding for the br_table immediate sequencer.
package br_table_ctrl_pkg;
  localparam logic [7:0] OP_BR_TABLE   = 8'h0E;
  localparam int         LEB_MAX_BYTES = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_TARGETS,
    ST_DEFAULT,
    ST_DONE,
    ST_ERROR
  } bt_state_e;
endpackage

// File: rtl/br_table_ctrl_leb128_u32_dec.sv
// Streaming unsigned LEB128 decoder: one byte per valid cycle, value is complete when last=1.
module leb128_u32_dec
  import br_table_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         byte_valid,
  input  logic [7:0]   data_byte,
  output logic [W-1:0] value,
  output logic         last,
  output logic         overflow
);
  logic [W-1:0] acc;
  logic [2:0]   nb;

  assign value    = acc | (W'(data_byte[6:0]) << (7 * nb));
  assign last     = byte_valid & ~data_byte[7];
  // Final byte may only contribute the top 4 bits of a u32 and must terminate.
  assign overflow = byte_valid & (nb == 3'(LEB_MAX_BYTES - 1)) &
                    (data_byte[7] | (|data_byte[6:4]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      nb  <= '0;
    end else if (clr || last || overflow) begin
      acc <= '0;
      nb  <= '0;
    end else if (byte_valid) begin
      acc <= value;
      nb  <= nb + 3'd1;
    end
  end
endmodule

// File: rtl/br_table_ctrl.sv
// br_table sequencer: streams immediates from code ROM, selects the branch depth for index.
module br_table_ctrl
  import br_table_ctrl_pkg::*;
#(
  parameter int ROM_ADDR = 6,
  parameter int LABEL_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ROM_ADDR-1:0] pc_in,
  input  logic [31:0]         index,
  output logic [ROM_ADDR-1:0] rom_addr,
  output logic                rom_en,
  input  logic [7:0]          rom_data,
  output logic                busy,
  output logic                done,
  output logic [LABEL_W-1:0]  label,
  output logic [ROM_ADDR-1:0] next_pc,
  output logic                error
);
  bt_state_e            state, state_nxt;
  logic [ROM_ADDR:0]    addr;       // extra MSB flags a read past the top of ROM
  logic                 byte_vld, wrap_q;
  logic [31:0]          idx;
  logic [LABEL_W-1:0]   cnt, tgt, sel;
  logic [LABEL_W-1:0]   dec_value;
  logic                 dec_last, dec_ovf;
  logic                 fetch, dec_vld, fail, field_end, accept;

  assign fetch     = (state == ST_COUNT) || (state == ST_TARGETS) || (state == ST_DEFAULT);
  assign dec_vld   = byte_vld & fetch;
  assign fail      = dec_vld & (wrap_q | dec_ovf);
  assign field_end = dec_last & ~fail;
  assign accept    = (state == ST_IDLE) & start;
  assign rom_addr  = addr[ROM_ADDR-1:0];

  leb128_u32_dec #(.W(LABEL_W)) u_dec (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept),
    .byte_valid(dec_vld),
    .data_byte (rom_data),
    .value     (dec_value),
    .last      (dec_last),
    .overflow  (dec_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = fetch;
    rom_en    = fetch;
    done      = (state == ST_DONE);
    error     = (state == ST_ERROR);
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_COUNT;
      ST_COUNT: begin
        if (fail)           state_nxt = ST_ERROR;
        else if (field_end) state_nxt = (dec_value == '0) ? ST_DEFAULT : ST_TARGETS;
      end
      ST_TARGETS: begin
        if (fail)                                          state_nxt = ST_ERROR;
        else if (field_end && (tgt + LABEL_W'(1)) == cnt)  state_nxt = ST_DEFAULT;
      end
      ST_DEFAULT: begin
        if (fail)           state_nxt = ST_ERROR;
        else if (field_end) state_nxt = ST_DONE;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      ST_ERROR:   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Byte issued at addr in one cycle is decoded the next; wrap_q tracks that byte's overflow bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr     <= '0;
      byte_vld <= 1'b0;
      wrap_q   <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      tgt      <= '0;
      sel      <= '0;
      label    <= '0;
      next_pc  <= '0;
    end else begin
      byte_vld <= fetch;
      wrap_q   <= fetch & addr[ROM_ADDR];
      if (accept) begin
        idx  <= index;
        addr <= {1'b0, pc_in};
      end else if (fetch) begin
        addr <= addr + 1'b1;
      end
      if (field_end) begin
        case (state)
          ST_COUNT: begin
            cnt <= dec_value;
            tgt <= '0;
          end
          ST_TARGETS: begin
            if (tgt == idx) sel <= dec_value;
            tgt <= tgt + LABEL_W'(1);
          end
          ST_DEFAULT: begin
            label   <= (idx >= cnt) ? dec_value : sel;
            next_pc <= addr[ROM_ADDR-1:0];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_br_table_ctrl.sv
// Directed bench for br_table_ctrl with a byte-walking reference model and per-cycle compare.
module tb_br_table_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  pc_in = '0;
  logic [31:0] index = '0;
  logic [5:0]  rom_addr;
  logic        rom_en;
  logic [7:0]  rom_data = '0;
  logic        busy, done, error;
  logic [31:0] label;
  logic [5:0]  next_pc;

  logic [7:0]  rom [64];

  int n_cmp = 0, n_bad = 0;
  int pos_cnt = 0, op_s = 0, ev_rel = -1;
  bit op_active = 0, exp_err = 0;
  int exp_lat = 0;
  logic [5:0]  exp_pc = '0, exp_npc = '0, model_npc = '0;
  logic [31:0] exp_label = '0, model_label = '0;

  br_table_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .index(index),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data), .busy(busy),
    .done(done), .label(label), .next_pc(next_pc), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One LEB128 u32 field starting at byte address a; k counts bytes consumed so far.
  function automatic void field(inout int a, inout int k, output longint v, output bit e);
    logic [7:0] b;
    v = 0; e = 0;
    for (int j = 0; j < 5; j++) begin
      if (a > 63) begin e = 1; return; end
      b = rom[a];
      if (j == 4 && (b[7] || b[6:4] != 3'd0)) begin e = 1; return; end
      v = v | (longint'(b[6:0]) << (7 * j));
      a++; k++;
      if (!b[7]) return;
    end
  endfunction

  function automatic void model(input logic [5:0] pc, input logic [31:0] idx, output bit err,
                                output int lat, output logic [31:0] lbl, output logic [5:0] npc);
    int a, k; longint cnt_v, v, idx_l; logic [31:0] sel; bit e;
    a = int'(pc); k = 0; err = 0; lat = 0; lbl = '0; npc = '0; sel = '0;
    idx_l = longint'({32'h0, idx});
    field(a, k, cnt_v, e);
    if (e) begin err = 1; lat = k + 3; return; end
    for (longint i = 0; i < cnt_v; i++) begin
      field(a, k, v, e);
      if (e) begin err = 1; lat = k + 3; return; end
      if (i == idx_l) sel = v[31:0];
    end
    field(a, k, v, e);
    if (e) begin err = 1; lat = k + 3; return; end
    lbl = (idx_l >= cnt_v) ? v[31:0] : sel;
    npc = a[5:0];
    lat = k + 2;
  endfunction

  always @(negedge clk) begin
    int rel;
    if (op_active) begin
      rel = pos_cnt - op_s;
      if ((done || error) && ev_rel < 0) ev_rel = rel;
      chk("busy", busy, rel < exp_lat);
      chk("rom_en", rom_en, rel < exp_lat);
      chk("done", done, rel == exp_lat && !exp_err);
      chk("error", error, rel == exp_lat && exp_err);
      if (rel < exp_lat) chk("rom_addr", rom_addr, 6'(exp_pc + 6'(rel - 1)));
      if (rel >= exp_lat) begin
        chk("label", label, exp_label);
        chk("next_pc", next_pc, exp_npc);
        op_active = 0;
      end
    end
  end

  task automatic run(input logic [5:0] pc, input logic [31:0] idx, input bit poke);
    bit e; int l; logic [31:0] lb; logic [5:0] np;
    model(pc, idx, e, l, lb, np);
    exp_err = e; exp_lat = l; exp_pc = pc;
    if (!e) begin model_label = lb; model_npc = np; end
    exp_label = model_label; exp_npc = model_npc; ev_rel = -1;
    @(negedge clk); #1;
    pc_in = pc; index = idx; start = 1'b1; op_s = pos_cnt; op_active = 1;
    @(negedge clk); #1; start = 1'b0;
    if (poke) begin
      @(negedge clk); #1; start = 1'b1; pc_in = 6'h00; index = 32'h0;
      @(negedge clk); #1; start = 1'b0;
    end
    for (int i = 0; i < 200 && op_active; i++) @(negedge clk);
    if (op_active) begin
      n_cmp++; n_bad++; op_active = 0;
      $display("FAIL timeout: pc %0h idx %0h no done/error within bound", pc, idx);
    end
    @(negedge clk); #1;
    chk("label_held", label, exp_label);
    chk("next_pc_held", next_pc, exp_npc);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    {rom[8'h10], rom[8'h11], rom[8'h12], rom[8'h13], rom[8'h14]} = {8'h03, 8'h00, 8'h01, 8'h02, 8'h05};
    {rom[8'h20], rom[8'h21], rom[8'h22], rom[8'h23], rom[8'h24], rom[8'h25]} =
      {8'h02, 8'h80, 8'h01, 8'h03, 8'h81, 8'h01};
    {rom[8'h30], rom[8'h31]} = {8'h00, 8'h04};
    {rom[0], rom[1], rom[2], rom[3], rom[4]} = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    {rom[8], rom[9], rom[10], rom[11], rom[12], rom[13], rom[14]} =
      {8'h01, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    {rom[8'h3E], rom[8'h3F]} = {8'h01, 8'h07};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rom_en", rom_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_rom_addr", rom_addr, 6'h0);
    chk("rst_label", label, 32'h0);
    chk("rst_next_pc", next_pc, 6'h0);
    #1 reset = 1'b1;

    run(6'h10, 32'd1, 0);
    chk("t1_label", label, 32'd1);
    chk("t1_next_pc", next_pc, 6'h15);
    chk("t1_latency", ev_rel, 7);
    run(6'h10, 32'd7, 0);
    chk("t1_oob_label", label, 32'd5);
    run(6'h10, 32'hFFFF_FFFF, 0);
    chk("t1_neg_label", label, 32'd5);
    run(6'h10, 32'd0, 0);
    run(6'h10, 32'd2, 0);

    run(6'h20, 32'd0, 0);
    chk("t2_label0", label, 32'd128);
    chk("t2_next_pc", next_pc, 6'h26);
    run(6'h20, 32'd1, 0);
    chk("t2_label1", label, 32'd3);
    run(6'h20, 32'd2, 0);
    chk("t2_label2", label, 32'd129);

    run(6'h30, 32'd0, 0);
    chk("t3_label", label, 32'd4);
    chk("t3_next_pc", next_pc, 6'h32);
    chk("t3_latency", ev_rel, 4);

    run(6'h00, 32'd0, 0);
    chk("ovf_latency", ev_rel, 7);
    chk("ovf_label_kept", label, 32'd4);
    chk("ovf_next_pc_kept", next_pc, 6'h32);

    run(6'h08, 32'd3, 0);
    chk("u32max_label", label, 32'hFFFF_FFFF);
    chk("u32max_next_pc", next_pc, 6'h0F);

    run(6'h3E, 32'd0, 0);
    chk("wrap_latency", ev_rel, 5);
    chk("wrap_label_kept", label, 32'hFFFF_FFFF);
    {rom[8'h3E], rom[8'h3F]} = {8'h00, 8'h06};
    run(6'h3E, 32'd0, 0);
    chk("edge_label", label, 32'd6);
    chk("edge_next_pc", next_pc, 6'h00);
    chk("edge_latency", ev_rel, 4);

    run(6'h20, 32'd1, 1);
    chk("poke_label", label, 32'd3);

    @(negedge clk); #1;
    pc_in = 6'h10; index = 32'd1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rom_en", rom_en, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_error", error, 1'b0);
    chk("mid_rst_label", label, 32'h0);
    model_label = '0; model_npc = '0;
    @(negedge clk); #1 reset = 1'b1;
    run(6'h10, 32'd2, 0);
    chk("post_rst_label", label, 32'd2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/br_table_ctrl.md
Name: br_table_ctrl

Overview:
- Sequencer the cpu core invokes when it decodes opcode 0x0E (br_table).
- Walks the instruction's immediates in code ROM byte by byte and LEB128-decodes them: a u32 target count, then that many u32 label indices, then a u32 default label.
- Returns the selected branch depth and the address of the next instruction.
- The core holds its stack unwinder stalled while busy=1, then uses label to unwind the block stack.

Parameters:
- ROM_ADDR, 6, code ROM address width in bytes; matches the cpu ROM_ADDR.
- LABEL_W, 32, width of decoded label/count values (u32 per wasm spec).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; accepted only when busy=0.
- pc_in  input  ROM_ADDR  address of the first immediate byte (opcode address + 1).
- index  input  32  i32 operand popped by the core, treated as unsigned.
- rom_addr  output  ROM_ADDR  byte address to code ROM.
- rom_en  output  1  ROM read enable.
- rom_data  input  8  ROM byte; synchronous ROM, valid the cycle after rom_addr/rom_en.
- busy  output  1  high from the cycle after start until done/error.
- done  output  1  one-cycle pulse; label/next_pc valid on this cycle and held until next start.
- label  output  LABEL_W  selected branch depth.
- next_pc  output  ROM_ADDR  address of the byte after the default label.
- error  output  1  one-cycle pulse on malformed immediate or address wrap.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, error, rom_en = 0; rom_addr, label, next_pc, internal counters = 0. Reset mid-operation aborts with no done/error pulse.
- States: IDLE, COUNT, TARGETS, DEFAULT, DONE, ERROR.
- IDLE, start=1: latch index; addr<=pc_in; go to COUNT. start while busy=1 is ignored.
- Fetch pipeline:
  - In COUNT/TARGETS/DEFAULT, rom_en=1 and rom_addr=addr; addr increments every cycle.
  - rom_data is consumed one cycle later, so one byte is decoded per cycle with no bubbles.
  - At most one speculative read is issued past the last byte; it is harmless.
- LEB128 decode per field:
  - acc |= (byte & 0x7F) << shift; shift += 7.
  - The field ends when byte[7]=0; acc and shift then clear.
- COUNT: on field end, cnt<=acc and tgt<=0. If acc==0, go to DEFAULT; else go to TARGETS.
- TARGETS:
  - On each field end, if tgt==index, sel<=acc (captured exactly once).
  - Then tgt<=tgt+1. When tgt+1==cnt, go to DEFAULT.
  - The scan always runs all cnt entries, because field lengths are variable.
- DEFAULT:
  - On field end, if index>=cnt (unsigned), label<=acc; else label<=sel.
  - next_pc <= address of this byte + 1.
  - Go to DONE.
- DONE: done=1, busy=0 for one cycle, then IDLE.
- ERROR: error=1 for one cycle, then IDLE; label and next_pc keep their previous values. Entered when:
  - a field reaches a 5th byte with byte[7]=1 or byte[6:4]!=0 (u32 overflow), or
  - addr would wrap past 2^ROM_ADDR-1 before the default field ends.
- Latency: for N immediate bytes, done asserts N+2 cycles after the start cycle.
- busy=1 exactly from the cycle after start through the cycle before done/error.

Decomposition:
- Shared package/header alongside cpu.vh holds the state encodings, the OP_BR_TABLE=8'h0E constant, and the LEB128 max-bytes constant (5).
- One natural sub-module: leb128_u32_dec.
  - Inputs: clk, reset, byte_valid, byte.
  - Outputs: value, last, overflow.
  - Reused later by the br/call/local decoders.

Test Plan:
- ROM @pc_in=0x10: 03 00 01 02 05, index=1 -> done at cycle 7, label=1, next_pc=0x15, error=0.
- Same ROM, index=7, then index=0xFFFFFFFF -> label=5 both times (unsigned out-of-range selects default).
- ROM: 02 80 01 03 81 01, index=0 -> label=128, next_pc=pc_in+6; index=1 -> label=3; index=2 -> label=129.
- ROM: 00 04, index=0 -> label=4, next_pc=pc_in+2, done 4 cycles after start.
- Malformed count FF FF FF FF 7F -> error pulse, no done. Separately, pc_in=0x3E with 3-byte immediate (ROM_ADDR=6) -> error on wrap.
- reset asserted while busy -> busy/done/error/rom_en=0 immediately. A new start after release completes normally, and start pulses during busy are ignored.
